sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO for byte/word buffering between SPI datapath stages (shift

---
 rtl/sync_fifo_param.sv | 133 +++++++++++++
 tb/tb_sync_fifo_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Parametrised single-clock FIFO (any DEPTH) with level, almost
//            thresholds, synchronous flush and overflow/underflow pulses.
//            Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 53,
    parameter int AF_THRESH  = 48,
    parameter int AE_THRESH  = 4,
    parameter int AW         = $clog2(DEPTH),
    parameter int LW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW-1:0] c_LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ONE_PTR  = AW'(1);
    localparam logic [LW-1:0] c_ONE_LVL  = LW'(1);
    localparam logic [LW-1:0] c_FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] c_AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] c_AE_LVL   = LW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [AW-1:0]         w_wr_ptr_nxt;
    logic [AW-1:0]         w_rd_ptr_nxt;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == c_FULL_LVL);
    assign w_wr_acc = wr_en && !w_full  && !clr;
    assign w_rd_acc = rd_en && !w_empty && !clr;

    // DEPTH need not be a power of two, so wrap is an explicit compare
    assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_ONE_PTR;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_ONE_PTR;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + c_ONE_LVL;
                2'b01:   r_level <= r_level - c_ONE_LVL;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; zero while empty so reset reads back clean
    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rd_valid = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_level <= c_AE_LVL);
    assign almost_full  = (r_level >= c_AF_LVL);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Brief    : Scoreboard bench for sync_fifo_param (standard or FWFT build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 53;
    localparam int AF    = 48;
    localparam int AE    = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] last_rd;

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus, entered and left at a falling edge
    task automatic cycle(input logic w, input logic [DW-1:0] wd, input logic r, input logic c);
        int            lvl;
        logic          wacc;
        logic          racc;
        logic          exp_ovf;
        logic          exp_unf;
        logic [DW-1:0] exp_rd;
        lvl     = sb.size();
        wacc    = w && (lvl != DEPTH) && !c;
        racc    = r && (lvl != 0) && !c;
        exp_ovf = w && (lvl == DEPTH) && !c;
        exp_unf = r && (lvl == 0) && !c;
        exp_rd  = last_rd;
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        clr     = c;
`ifdef SYNC_FIFO_FWFT_EN
        if (racc) begin
            check("fwft_head_valid", rd_valid, 1);
            check("fwft_head_data", rd_data, sb[0]);
        end
`endif
        @(posedge clk);
        #1;
        if (c) begin
            sb.delete();
        end else begin
            if (racc) exp_rd = sb.pop_front();
            if (wacc) sb.push_back(wd);
        end
        lvl = sb.size();
        check("level", level, lvl);
        check("empty", empty, lvl == 0);
        check("full", full, lvl == DEPTH);
        check("almost_empty", almost_empty, lvl <= AE);
        check("almost_full", almost_full, lvl >= AF);
        check("overflow", overflow, exp_ovf);
        check("underflow", underflow, exp_unf);
`ifdef SYNC_FIFO_FWFT_EN
        check("rd_valid", rd_valid, lvl != 0);
        if (lvl != 0) check("rd_data", rd_data, sb[0]);
`else
        check("rd_valid", rd_valid, racc);
        last_rd = exp_rd;
        check("rd_data", rd_data, last_rd);
`endif
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_ae"}, almost_empty, 1);
        check({tag, "_af"}, almost_full, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_unf"}, underflow, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset pulse in the middle of traffic
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        rd_en   = 1'b1;
        rst_n   = 1'b0;
        #1;
        check_reset_state("async_rst");
        sb.delete();
        last_rd = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, then one refused write
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Drain in order, then one refused read
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Pointer wrap-around
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous read/write at full, empty and mid level
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h88, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h90 + i), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with both requests active, then reuse
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
